// File: rtl/wifi_interleaver_pkg.sv
// -----------------------------------------------------------------------------
// wifi_interleaver_pkg
// Shared definitions for the 802.11a/g interleaver and the future deinterleaver:
// modulation mode encoding, per-mode N_CBPS / s lookups and the bank-state enum.
// -----------------------------------------------------------------------------
package wifi_interleaver_pkg;

  localparam logic [1:0] MODE_BPSK  = 2'd0;
  localparam logic [1:0] MODE_QPSK  = 2'd1;
  localparam logic [1:0] MODE_QAM16 = 2'd2;
  localparam logic [1:0] MODE_QAM64 = 2'd3;

  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  // Coded bits per OFDM symbol for each mode.
  function automatic logic [8:0] n_cbps_of(input logic [1:0] m);
    logic [8:0] n;
    case (m)
      MODE_BPSK:  n = 9'd48;
      MODE_QPSK:  n = 9'd96;
      MODE_QAM16: n = 9'd192;
      default:    n = 9'd288;
    endcase
    return n;
  endfunction

  // s = max(N_BPSC/2, 1) for each mode.
  function automatic logic [1:0] s_of(input logic [1:0] m);
    logic [1:0] s;
    case (m)
      MODE_BPSK:  s = 2'd1;
      MODE_QPSK:  s = 2'd1;
      MODE_QAM16: s = 2'd2;
      default:    s = 2'd3;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/wifi_interleaver_multi_addr_gen.sv
// -----------------------------------------------------------------------------
// interleaver_addr_gen
// Combinational map from input bit index k to interleaved address j, covering
// both permutations (column/row, then adjacent-bit rotation within groups of s).
// Ports:
//   i_mode  modulation mode (selects N_CBPS and s)
//   i_k     input bit index, 0..N_CBPS-1
//   o_j     buffer address for that bit
// -----------------------------------------------------------------------------
module interleaver_addr_gen
  import wifi_interleaver_pkg::*;
#(
  parameter int CNT_W = 9
) (
  input  logic [1:0]       i_mode,
  input  logic [CNT_W-1:0] i_k,
  output logic [CNT_W-1:0] o_j
);

  logic [CNT_W-1:0] w_col;
  logic [CNT_W-1:0] w_row;
  logic [CNT_W-1:0] w_i;
  logic [CNT_W-1:0] w_f;

  assign w_col = {{(CNT_W-4){1'b0}}, i_k[3:0]};
  assign w_row = i_k >> 4;

  // floor(16*i/N_CBPS) is computed as floor(i/N_ROWS) so it never overflows.
  always_comb begin
    w_i = '0;
    w_f = '0;
    o_j = '0;
    case (i_mode)
      MODE_BPSK: begin
        w_i = CNT_W'(3) * w_col + w_row;
        o_j = w_i;
      end
      MODE_QPSK: begin
        w_i = CNT_W'(6) * w_col + w_row;
        o_j = w_i;
      end
      MODE_QAM16: begin
        // s=2 and N_CBPS even: the rotation is just the parity of (i - f).
        w_i = CNT_W'(12) * w_col + w_row;
        w_f = w_i / CNT_W'(12);
        o_j = {w_i[CNT_W-1:1], w_i[0] ^ w_f[0]};
      end
      default: begin
        // s=3: 288 is congruent to 18 mod 3; 18 >= max f keeps the sum positive
        // and inside CNT_W bits.
        w_i = CNT_W'(18) * w_col + w_row;
        w_f = w_i / CNT_W'(18);
        o_j = (w_i / CNT_W'(3)) * CNT_W'(3)
            + (w_i + CNT_W'(18) - w_f) % CNT_W'(3);
      end
    endcase
  end

endmodule

// File: rtl/wifi_interleaver_multi.sv
// -----------------------------------------------------------------------------
// wifi_interleaver_multi
// 802.11a/g block interleaver for BPSK/QPSK/16-QAM/64-QAM with a ping-pong
// bit buffer. One bank is written in permuted order while the other is read
// sequentially, so back-to-back symbols stream without bubbles.
// Ports:
//   Clock, Reset           rising-edge clock, async active-high reset
//   mode                   modulation select, sampled on the first bit of a symbol
//   in_bit/in_valid/in_ready     input stream
//   out_bit/out_valid/out_ready  output stream
//   out_last               final bit of a symbol
//   out_mode               mode of the symbol being output
// Handshake: a beat moves on a rising edge where valid && ready; valid never
// depends on ready, and the payload holds steady while valid && !ready.
// -----------------------------------------------------------------------------
module wifi_interleaver_multi
  import wifi_interleaver_pkg::*;
#(
  parameter int MAX_N_CBPS = 288,
  parameter int CNT_W      = 9
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [1:0] mode,
  input  logic       in_bit,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_bit,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last,
  output logic [1:0] out_mode
);

  logic [MAX_N_CBPS-1:0] r_bank [2];
  bank_state_t           r_state [2];
  logic                  r_wr_bank;
  logic [CNT_W-1:0]      r_wr_cnt;
  logic [CNT_W-1:0]      r_rd_cnt;
  logic [1:0]            r_wr_mode;
  logic [1:0]            r_rd_mode;
  logic                  r_out_valid;

  logic                  w_rd_bank;
  logic [1:0]            w_cur_mode;
  logic [CNT_W-1:0]      w_wr_last_idx;
  logic [CNT_W-1:0]      w_rd_last_idx;
  logic [CNT_W-1:0]      w_wr_addr;
  logic                  w_wr_full;
  logic                  w_in_fire;
  logic                  w_out_fire;
  logic                  w_wr_done;
  logic                  w_rd_done;
  logic                  w_rd_idle;
  logic                  w_swap;

  // The read bank is always the one not being written.
  assign w_rd_bank = ~r_wr_bank;

  // At k=0 the live mode input applies; afterwards the captured one.
  assign w_cur_mode    = (r_wr_cnt == '0) ? mode : r_wr_mode;
  assign w_wr_last_idx = CNT_W'(n_cbps_of(w_cur_mode)) - CNT_W'(1);
  assign w_rd_last_idx = CNT_W'(n_cbps_of(r_rd_mode)) - CNT_W'(1);

  assign w_wr_full  = (r_state[r_wr_bank] == BANK_FULL);
  assign in_ready   = ~w_wr_full;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_out_valid & out_ready;
  assign w_wr_done  = w_in_fire & (r_wr_cnt == w_wr_last_idx);
  assign w_rd_done  = w_out_fire & (r_rd_cnt == w_rd_last_idx);
  assign w_rd_idle  = ~r_out_valid | w_rd_done;
  // Swap on the completing write edge itself, or later once the reader frees up.
  assign w_swap     = (w_wr_done | w_wr_full) & w_rd_idle;

  interleaver_addr_gen #(.CNT_W(CNT_W)) u_addr_gen (
    .i_mode (w_cur_mode),
    .i_k    (r_wr_cnt),
    .o_j    (w_wr_addr)
  );

  // Buffer contents need no reset: a bank is only read after a full write.
  always_ff @(posedge Clock) begin
    if (w_in_fire) r_bank[r_wr_bank][w_wr_addr] <= in_bit;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state[0]  <= BANK_EMPTY;
      r_state[1]  <= BANK_EMPTY;
      r_wr_bank   <= 1'b0;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_wr_mode   <= MODE_BPSK;
      r_rd_mode   <= MODE_BPSK;
      r_out_valid <= 1'b0;
    end else begin
      if (w_in_fire) begin
        if (r_wr_cnt == '0) r_wr_mode <= mode;
        r_wr_cnt <= w_wr_done ? '0 : r_wr_cnt + CNT_W'(1);
      end
      if (w_swap) begin
        r_wr_bank           <= w_rd_bank;
        r_state[r_wr_bank]  <= BANK_FULL;
        r_state[w_rd_bank]  <= BANK_EMPTY;
        r_rd_mode           <= r_wr_mode;
        r_rd_cnt            <= '0;
        r_out_valid         <= 1'b1;
      end else begin
        if (w_in_fire) r_state[r_wr_bank] <= w_wr_done ? BANK_FULL : BANK_FILLING;
        if (w_rd_done) begin
          r_state[w_rd_bank] <= BANK_EMPTY;
          r_out_valid        <= 1'b0;
          r_rd_cnt           <= '0;
        end else if (w_out_fire) begin
          r_rd_cnt <= r_rd_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_bit   = r_out_valid & r_bank[w_rd_bank][r_rd_cnt];
  assign out_last  = r_out_valid & (r_rd_cnt == w_rd_last_idx);
  assign out_mode  = r_rd_mode;

endmodule

// File: tb/tb_wifi_interleaver_multi.sv
// -----------------------------------------------------------------------------
// tb_wifi_interleaver_multi
// Directed bench: one-hot vectors with hand-computed output positions, a golden
// address model feeding an expected queue, and sequences for streaming,
// back-pressure and reset in mid-symbol.
// -----------------------------------------------------------------------------
module tb_wifi_interleaver_multi;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [1:0] mode;
  logic       in_bit;
  logic       in_valid;
  logic       in_ready;
  logic       out_bit;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic [1:0] out_mode;

  // ---------------- clock / reset ----------------
  always #5 Clock = ~Clock;

  int cyc = 0;
  initial forever begin
    @(posedge Clock);
    cyc++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  wifi_interleaver_multi dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .mode      (mode),
    .in_bit    (in_bit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_bit   (out_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .out_mode  (out_mode)
  );

  // ---------------- scoreboard state ----------------
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [3:0] exp_q[$];   // {mode, last, bit}
  logic       got_q[$];
  int         n_stall = 0;
  int         last_acc_cyc = 0;
  int         rise_cyc = -1;
  bit         gap_watch = 0;
  int         gap_cnt = 0;
  bit         prev_hold = 0;
  logic       prev_valid = 1'b0;
  logic       prev_bit, prev_last;
  logic [1:0] prev_mode;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  function automatic int n_of(input logic [1:0] m);
    case (m)
      2'd0:    return 48;
      2'd1:    return 96;
      2'd2:    return 192;
      default: return 288;
    endcase
  endfunction

  function automatic int s_model(input logic [1:0] m);
    return (m == 2'd3) ? 3 : (m == 2'd2) ? 2 : 1;
  endfunction

  // Golden address, written straight from the two permutation formulas.
  function automatic int model_j(input logic [1:0] m, input int k);
    int n, s, i;
    n = n_of(m);
    s = s_model(m);
    i = (n / 16) * (k % 16) + k / 16;
    return s * (i / s) + (i + n - (16 * i) / n) % s;
  endfunction

  // ---------------- monitor ----------------
  initial forever begin
    logic [3:0] e;
    @(negedge Clock);
    if (Reset) begin
      prev_hold  = 0;
      prev_valid = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", out_valid, 1);
        check("hold_bit", out_bit, prev_bit);
        check("hold_last", out_last, prev_last);
        check("hold_mode", out_mode, prev_mode);
      end
      if (out_valid && !prev_valid) rise_cyc = cyc;
      if (gap_watch && exp_q.size() > 0 && !out_valid) gap_cnt++;
      if (out_valid && out_ready) begin
        got_q.push_back(out_bit);
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL extra_bit: got an output bit %0d, expected none", out_bit);
        end else begin
          e = exp_q.pop_front();
          check("out_bit", out_bit, e[0]);
          check("out_last", out_last, e[1]);
          check("out_mode", out_mode, e[3:2]);
        end
      end
      prev_hold  = out_valid && !out_ready;
      prev_bit   = out_bit;
      prev_last  = out_last;
      prev_mode  = out_mode;
      prev_valid = out_valid;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic b);
    bit acc;
    int w;
    w = 0;
    in_valid = 1'b1;
    in_bit   = b;
    forever begin
      @(negedge Clock);
      acc = in_ready;
      @(posedge Clock);
      #1;
      if (acc) begin
        last_acc_cyc = cyc;
        break;
      end
      n_stall++;
      w++;
      if (w > 2000) begin
        n_checks++;
        $display("FAIL in_ready_timeout: waited %0d cycles, expected acceptance", w);
        break;
      end
    end
  endtask

  // Drives the first n_send bits; a complete symbol also queues its expected output.
  task automatic send_symbol(input logic [1:0] m, input logic [287:0] bits,
                             input int n_send, input bit scramble);
    logic [287:0] o;
    int n;
    n = n_of(m);
    o = '0;
    if (n_send == n) begin
      for (int k = 0; k < n; k++) o[model_j(m, k)] = bits[k];
      for (int idx = 0; idx < n; idx++)
        exp_q.push_back({m, (idx == n - 1) ? 1'b1 : 1'b0, o[idx]});
    end
    mode = m;
    for (int k = 0; k < n_send; k++) begin
      if (scramble && k > 0) mode = 2'($urandom_range(0, 3));
      send_bit(bits[k]);
    end
  endtask

  task automatic wait_drain(input int limit);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < limit) begin
      @(posedge Clock);
      #1;
      w++;
    end
    check("drain_remaining", exp_q.size(), 0);
    repeat (2) @(posedge Clock);
    #1;
  endtask

  task automatic find_one(output int idx, output int cnt);
    idx = -1;
    cnt = 0;
    foreach (got_q[p]) if (got_q[p]) begin
      idx = p;
      cnt++;
    end
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [1:0] m;
    int         k;
    int         exp_idx;
  } vec_t;

  vec_t vecs[9];

  // ---------------- main sequence ----------------
  initial begin
    logic [287:0] bits;
    int idx, cnt;

    vecs[0] = '{2'd0, 1, 3};
    vecs[1] = '{2'd2, 1, 13};
    vecs[2] = '{2'd3, 1, 20};
    vecs[3] = '{2'd0, 47, 47};
    vecs[4] = '{2'd1, 95, 95};
    vecs[5] = '{2'd3, 0, 0};
    vecs[6] = '{2'd3, 287, 287};
    vecs[7] = '{2'd2, 16, 1};
    vecs[8] = '{2'd3, 2, 37};

    Reset = 1'b1; mode = 2'd0; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bit", out_bit, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_mode", out_mode, 0);
    Reset = 1'b0;
    @(posedge Clock);
    #1;
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);

    // QPSK one-hot at k=1: latency, position, last, mode
    got_q.delete();
    rise_cyc = -1;
    bits = '0; bits[1] = 1'b1;
    send_symbol(2'd1, bits, 96, 0);
    in_valid = 1'b0;
    check("qpsk_first_valid", out_valid, 1);
    check("qpsk_first_bit", out_bit, 0);
    wait_drain(500);
    check("qpsk_latency_cyc", rise_cyc, last_acc_cyc);
    find_one(idx, cnt);
    check("qpsk_one_idx", idx, 6);
    check("qpsk_one_cnt", cnt, 1);
    check("qpsk_len", got_q.size(), 96);
    check("qpsk_valid_drop", out_valid, 0);

    // Table of one-hot vectors
    for (int v = 0; v < 9; v++) begin
      got_q.delete();
      bits = '0;
      bits[vecs[v].k] = 1'b1;
      send_symbol(vecs[v].m, bits, n_of(vecs[v].m), 0);
      in_valid = 1'b0;
      wait_drain(1000);
      find_one(idx, cnt);
      check($sformatf("vec%0d_one_idx", v), idx, vecs[v].exp_idx);
      check($sformatf("vec%0d_one_cnt", v), cnt, 1);
      check($sformatf("vec%0d_valid_drop", v), out_valid, 0);
    end

    // 64-QAM counting-style pattern, mode input changing after k=0
    bits = {9{32'hA5C3_0F96}};
    send_symbol(2'd3, bits, 288, 1);
    in_valid = 1'b0;
    wait_drain(1000);

    // Back-to-back symbols of modes 0, 3, 2
    n_stall = 0;
    gap_cnt = 0;
    send_symbol(2'd0, {9{32'h1234_5678}}, 48, 0);
    send_symbol(2'd3, {9{32'hDEAD_BEEF}}, 288, 0);
    send_symbol(2'd2, {9{32'h0F1E_2D3C}}, 192, 0);
    in_valid = 1'b0;
    gap_watch = 1;
    wait_drain(1000);
    gap_watch = 0;
    check("b2b_stalls", n_stall, 0);
    check("b2b_gaps", gap_cnt, 0);

    // Back-pressure: reader stalled, second symbol fills and blocks input
    out_ready = 1'b0;
    n_stall = 0;
    send_symbol(2'd1, {9{32'h8E3A_61C5}}, 96, 0);
    send_symbol(2'd1, {9{32'h5B07_F2D9}}, 96, 0);
    in_valid = 1'b0;
    check("bp_no_stall_while_filling", n_stall, 0);
    check("bp_in_ready_low", in_ready, 0);
    repeat (108) @(posedge Clock);
    #1;
    check("bp_in_ready_still_low", in_ready, 0);
    check("bp_out_valid_held", out_valid, 1);
    out_ready = 1'b1;
    wait_drain(1000);
    check("bp_in_ready_back", in_ready, 1);

    // Reset in the middle of a 64-QAM symbol while a QPSK symbol waits to be read
    out_ready = 1'b0;
    send_symbol(2'd1, {9{32'hC0FF_EE11}}, 96, 0);
    send_symbol(2'd3, {9{32'h3141_5926}}, 100, 0);
    check("pre_rst_out_valid", out_valid, 1);
    check("pre_rst_out_mode", out_mode, 1);
    in_valid = 1'b0;
    Reset = 1'b1;
    #1;
    exp_q.delete();
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_bit", out_bit, 0);
    check("mid_rst_out_last", out_last, 0);
    check("mid_rst_out_mode", out_mode, 0);
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    out_ready = 1'b1;
    @(posedge Clock);
    #1;
    got_q.delete();
    send_symbol(2'd0, {9{32'h96C3_5AF0}}, 48, 0);
    in_valid = 1'b0;
    wait_drain(500);
    check("after_rst_len", got_q.size(), 48);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
